// File: rtl/mkio_channel_arbiter.sv
// Dual-redundant MKIO bus channel arbiter: picks the live receive channel,
// steers the transmitter onto the selected channel and counts parity errors.
module mkio_channel_arbiter #(
   parameter int GAP_CYC    = 128,
   parameter int SWITCH_CYC = 32,
   parameter int TX_HOLD    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       DI1A,
   input  logic       DI0A,
   input  logic       DI1B,
   input  logic       DI0B,
   output logic       DI1,
   output logic       DI0,
   input  logic       DO1,
   input  logic       DO0,
   output logic       DO1A,
   output logic       DO0A,
   output logic       DO1B,
   output logic       DO0B,
   output logic       TX_INHIBIT_A,
   output logic       TX_INHIBIT_B,
   output logic       RX_STROB_A,
   output logic       RX_STROB_B,
   input  logic       tx_busy,
   input  logic       parity_error,
   output logic       active_ch,
   output logic       ch_switch,
   output logic [7:0] err_cnt_a,
   output logic [7:0] err_cnt_b
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RX   = 2'd1;
   localparam logic [1:0] S_TX   = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   localparam int QW = $clog2(GAP_CYC + 1);
   localparam int SW = $clog2(SWITCH_CYC + 1);
   localparam int HW = $clog2(TX_HOLD + 1);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      if (v == 8'hFF) begin
         return 8'hFF;
      end else begin
         return v + 8'd1;
      end
   endfunction

   logic [3:0]    meta_r;
   logic [3:0]    sync_r;
   logic [1:0]    state_r;
   logic [1:0]    state_nxt_s;
   logic          active_ch_r;
   logic          ch_nxt_s;
   logic          switch_nxt_s;
   logic [QW-1:0] quiet_r;
   logic [QW-1:0] quiet_nxt_s;
   logic [SW-1:0] other_r;
   logic [SW-1:0] other_nxt_s;
   logic [HW-1:0] hold_r;
   logic [HW-1:0] hold_nxt_s;
   logic          act_a_s;
   logic          act_b_s;
   logic          act_sel_s;
   logic          act_oth_s;
   logic [1:0]    sel_pair_s;
   logic          grant_a_s;
   logic          grant_b_s;

   assign act_a_s    = sync_r[3] | sync_r[2];
   assign act_b_s    = sync_r[1] | sync_r[0];
   assign act_sel_s  = active_ch_r ? act_b_s : act_a_s;
   assign act_oth_s  = active_ch_r ? act_a_s : act_b_s;
   assign sel_pair_s = ch_nxt_s ? sync_r[1:0] : sync_r[3:2];
   assign grant_a_s  = ((state_nxt_s == S_TX) || (state_nxt_s == S_HOLD)) && !ch_nxt_s;
   assign grant_b_s  = ((state_nxt_s == S_TX) || (state_nxt_s == S_HOLD)) && ch_nxt_s;
   assign active_ch  = active_ch_r;

   // Next-state logic; tx_busy outranks both the switch and the gap decision.
   always_comb begin
      state_nxt_s  = state_r;
      ch_nxt_s     = active_ch_r;
      switch_nxt_s = 1'b0;
      quiet_nxt_s  = quiet_r;
      other_nxt_s  = other_r;
      hold_nxt_s   = hold_r;
      case (state_r)
         S_IDLE: begin
            quiet_nxt_s = '0;
            other_nxt_s = '0;
            hold_nxt_s  = '0;
            if (tx_busy) begin
               state_nxt_s = S_TX;
            end else if (act_a_s) begin
               state_nxt_s = S_RX;
               ch_nxt_s    = 1'b0;
            end else if (act_b_s) begin
               state_nxt_s = S_RX;
               ch_nxt_s    = 1'b1;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_RX: begin
            if (tx_busy) begin
               state_nxt_s = S_TX;
               quiet_nxt_s = '0;
               other_nxt_s = '0;
            end else if (act_oth_s && (other_r == SW'(SWITCH_CYC - 1))) begin
               ch_nxt_s     = ~active_ch_r;
               switch_nxt_s = 1'b1;
               quiet_nxt_s  = '0;
               other_nxt_s  = '0;
            end else begin
               other_nxt_s = act_oth_s ? (other_r + SW'(1)) : '0;
               if (act_sel_s) begin
                  quiet_nxt_s = '0;
               end else if (quiet_r == QW'(GAP_CYC - 2)) begin
                  // counter would now read GAP_CYC-1: message is over
                  state_nxt_s = S_IDLE;
                  quiet_nxt_s = '0;
                  other_nxt_s = '0;
               end else begin
                  quiet_nxt_s = quiet_r + QW'(1);
               end
            end
         end
         S_TX: begin
            if (!tx_busy) begin
               state_nxt_s = S_HOLD;
               hold_nxt_s  = '0;
            end else begin
               state_nxt_s = S_TX;
            end
         end
         S_HOLD: begin
            if (tx_busy) begin
               state_nxt_s = S_TX;
            end else if (hold_r == HW'(TX_HOLD - 1)) begin
               state_nxt_s = S_IDLE;
            end else begin
               hold_nxt_s = hold_r + HW'(1);
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // Line-input synchronizers and arbiter state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_r      <= 4'b0000;
         sync_r      <= 4'b0000;
         state_r     <= S_IDLE;
         active_ch_r <= 1'b0;
         quiet_r     <= '0;
         other_r     <= '0;
         hold_r      <= '0;
      end else begin
         meta_r      <= {DI1A, DI0A, DI1B, DI0B};
         sync_r      <= meta_r;
         state_r     <= state_nxt_s;
         active_ch_r <= ch_nxt_s;
         quiet_r     <= quiet_nxt_s;
         other_r     <= other_nxt_s;
         hold_r      <= hold_nxt_s;
      end
   end

   // Registered outputs are driven from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         {DI1, DI0}   <= 2'b00;
         {DO1A, DO0A} <= 2'b00;
         {DO1B, DO0B} <= 2'b00;
         TX_INHIBIT_A <= 1'b1;
         TX_INHIBIT_B <= 1'b1;
         RX_STROB_A   <= 1'b1;
         RX_STROB_B   <= 1'b1;
         ch_switch    <= 1'b0;
      end else begin
         {DI1, DI0}   <= (state_nxt_s == S_RX) ? sel_pair_s : 2'b00;
         {DO1A, DO0A} <= ((state_nxt_s == S_TX) && !ch_nxt_s) ? {DO1, DO0} : 2'b00;
         {DO1B, DO0B} <= ((state_nxt_s == S_TX) && ch_nxt_s) ? {DO1, DO0} : 2'b00;
         TX_INHIBIT_A <= ~grant_a_s;
         TX_INHIBIT_B <= ~grant_b_s;
         RX_STROB_A   <= ~grant_a_s;
         RX_STROB_B   <= ~grant_b_s;
         ch_switch    <= switch_nxt_s;
      end
   end

   // Saturating per-channel parity-error counters, live only while receiving.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_a <= 8'd0;
         err_cnt_b <= 8'd0;
      end else if ((state_r == S_RX) && parity_error) begin
         if (active_ch_r) begin
            err_cnt_b <= sat_inc(err_cnt_b);
         end else begin
            err_cnt_a <= sat_inc(err_cnt_a);
         end
      end else begin
         err_cnt_a <= err_cnt_a;
         err_cnt_b <= err_cnt_b;
      end
   end

endmodule
